id_counter: RTL and testbench

- Increment/decrement (pulse add/delete) counter of the all-digital PLL loop.
- Consumes the carry and borrow pulses produced by the loop's up/down K-counter.
- Produces the square-wave idout that feeds the divide-by-N stage.
- A carry shortens one idout half-period by one IDclock cycle (phase advance); a borrow lengthens one by one cycle (phase retard).

---
 rtl/id_counter_pkg.sv | 23 ++
 rtl/id_edge_capture.sv | 58 +++++
 rtl/id_counter.sv | 129 ++++++++++++
 tb/tb_id_counter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_counter_pkg.sv
// Shared types and sizing helpers for the DPLL increment/decrement counter.
package id_counter_pkg;

    // Kind of the idout half-period currently being timed.
    typedef enum logic [1:0] {
        NOM = 2'd0,   // nominal length
        ADV = 2'd1,   // one IDclock shorter (phase advance)
        RET = 2'd2    // one IDclock longer (phase retard)
    } id_state_t;

    localparam int PEND_W_DEF = 4;

    // The half-period counter must hold lengths up to HALF_NOM+1.
    function automatic int hcnt_width(input int half_nom);
        return $clog2(half_nom + 2);
    endfunction

    // Saturation value of a pending-request counter.
    function automatic int pend_max(input int pend_w);
        return (1 << pend_w) - 1;
    endfunction

endpackage

// File: rtl/id_edge_capture.sv
// Rising-edge detector plus saturating pending-request counter.
// add_i requests +1, consume_i and cancel_i each request -1; the owner
// guarantees the count never goes below zero. drop_o pulses when an add
// would push the count past its saturation value.
module id_edge_capture
    import id_counter_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              level_i,
    input  logic              add_i,
    input  logic              consume_i,
    input  logic              cancel_i,
    output logic              edge_o,
    output logic [PEND_W-1:0] pend_o,
    output logic              drop_o
);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(pend_max(PEND_W));

    logic              level_q;
    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_d;
    logic [PEND_W+1:0] sum;

    // Edges only count while enabled; the history register tracks regardless.
    assign edge_o = enable_i & level_i & ~level_q;
    assign pend_o = pend_q;

    // Level history, updated every cycle so a held level is never recounted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) level_q <= 1'b0;
        else         level_q <= level_i;
    end

    // Net update of the pending count, clamped at the saturation value.
    always_comb begin
        sum = {2'b00, pend_q}
            + {{(PEND_W+1){1'b0}}, add_i}
            - {{(PEND_W+1){1'b0}}, consume_i}
            - {{(PEND_W+1){1'b0}}, cancel_i};
        pend_d = sum[PEND_W-1:0];
        drop_o = 1'b0;
        if (sum > {2'b00, PEND_MAX}) begin
            pend_d = PEND_MAX;
            drop_o = 1'b1;
        end
    end

    // Pending count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pend_q <= '0;
        else         pend_q <= pend_d;
    end

endmodule

// File: rtl/id_counter.sv
// DPLL increment/decrement counter: generates idout at IDclock/(2*HALF_NOM)
// and shortens (carry on inc) or lengthens (borrow on dec) one half-period
// per queued request.
// Optional build macro IDCNT_CANCEL_EN: opposite requests annihilate instead
// of queueing independently.
module id_counter
    import id_counter_pkg::*;
#(
    parameter int HALF_NOM = 2,
    parameter int PEND_W   = PEND_W_DEF
) (
    input  logic IDclock,
    input  logic reset,
    input  logic enable,
    input  logic inc,
    input  logic dec,
    output logic idout,
    output logic busy,
    output logic ovf
);
    localparam int            HW      = hcnt_width(HALF_NOM);
    localparam logic [HW-1:0] LEN_NOM = HW'(HALF_NOM);
    localparam logic [HW-1:0] LEN_ADV = HW'(HALF_NOM - 1);
    localparam logic [HW-1:0] LEN_RET = HW'(HALF_NOM + 1);
    localparam logic [HW-1:0] ONE     = HW'(1);

    id_state_t         state_q, state_d;
    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic              idout_q, idout_d;
    logic              ovf_q;
    logic              consume_inc, consume_dec;
    logic              inc_edge, dec_edge;
    logic              inc_add, dec_add, inc_cancel, dec_cancel;
    logic              inc_drop, dec_drop;
    logic [PEND_W-1:0] inc_pend, dec_pend;

`ifdef IDCNT_CANCEL_EN
    // A request is "live" if it survives this cycle's boundary consumption;
    // only a live opposite request can absorb a new edge.
    logic inc_live, dec_live;
    assign inc_live   = inc_pend > PEND_W'(consume_inc);
    assign dec_live   = dec_pend > PEND_W'(consume_dec);
    assign inc_add    = inc_edge & ~dec_edge & ~dec_live;
    assign dec_cancel = inc_edge & ~dec_edge &  dec_live;
    assign dec_add    = dec_edge & ~inc_edge & ~inc_live;
    assign inc_cancel = dec_edge & ~inc_edge &  inc_live;
`else
    assign inc_add    = inc_edge;
    assign dec_add    = dec_edge;
    assign inc_cancel = 1'b0;
    assign dec_cancel = 1'b0;
`endif

    id_edge_capture #(.PEND_W(PEND_W)) u_inc_cap (
        .clk_i     (IDclock),
        .rst_ni    (reset),
        .enable_i  (enable),
        .level_i   (inc),
        .add_i     (inc_add),
        .consume_i (consume_inc),
        .cancel_i  (inc_cancel),
        .edge_o    (inc_edge),
        .pend_o    (inc_pend),
        .drop_o    (inc_drop)
    );

    id_edge_capture #(.PEND_W(PEND_W)) u_dec_cap (
        .clk_i     (IDclock),
        .rst_ni    (reset),
        .enable_i  (enable),
        .level_i   (dec),
        .add_i     (dec_add),
        .consume_i (consume_dec),
        .cancel_i  (dec_cancel),
        .edge_o    (dec_edge),
        .pend_o    (dec_pend),
        .drop_o    (dec_drop)
    );

    // Half-period timing and correction selection; inc wins over dec.
    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        idout_d     = idout_q;
        consume_inc = 1'b0;
        consume_dec = 1'b0;
        if (enable) begin
            if (hcnt_q == ONE) begin
                idout_d = ~idout_q;
                if (inc_pend != '0) begin
                    state_d     = ADV;
                    consume_inc = 1'b1;
                end else if (dec_pend != '0) begin
                    state_d     = RET;
                    consume_dec = 1'b1;
                end else begin
                    state_d = NOM;
                end
                case (state_d)
                    ADV:     hcnt_d = LEN_ADV;
                    RET:     hcnt_d = LEN_RET;
                    default: hcnt_d = LEN_NOM;
                endcase
            end else begin
                hcnt_d = hcnt_q - ONE;
            end
        end
    end

    // State, counter, output and sticky overflow registers.
    always_ff @(posedge IDclock or negedge reset) begin
        if (!reset) begin
            state_q <= NOM;
            hcnt_q  <= LEN_NOM;
            idout_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            idout_q <= idout_d;
            ovf_q   <= ovf_q | inc_drop | dec_drop;
        end
    end

    assign idout = idout_q;
    assign ovf   = ovf_q;
    assign busy  = (inc_pend != '0) | (dec_pend != '0);

endmodule

// File: tb/tb_id_counter.sv
// Self-checking bench for id_counter (HALF_NOM=2, PEND_W=4).
module tb_id_counter;
    localparam int H    = 2;
    localparam int PW   = 4;
    localparam int PMAX = 15;

    logic IDclock = 1'b0;
    logic reset   = 1'b0;
    logic enable  = 1'b0;
    logic inc     = 1'b0;
    logic dec     = 1'b0;
    logic idout, busy, ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: remaining cycles in the half-period, request
    // bookkeeping as plain integers.
    bit m_idout, m_ovf, m_inc_prev, m_dec_prev;
    int m_rem;
`ifdef IDCNT_CANCEL_EN
    int m_bal;  // >0: queued advances, <0: queued retards
`else
    int m_ip, m_dp;
`endif

    int   edge_n;
    int   tog_q[$];
    logic prev_idout;

    id_counter #(.HALF_NOM(H), .PEND_W(PW)) dut (
        .IDclock (IDclock),
        .reset   (reset),
        .enable  (enable),
        .inc     (inc),
        .dec     (dec),
        .idout   (idout),
        .busy    (busy),
        .ovf     (ovf)
    );

    always #5 IDclock = ~IDclock;

    function automatic bit m_busy();
`ifdef IDCNT_CANCEL_EN
        return m_bal != 0;
`else
        return (m_ip != 0) || (m_dp != 0);
`endif
    endfunction

    task automatic model_reset();
        m_idout = 0; m_ovf = 0; m_inc_prev = 0; m_dec_prev = 0; m_rem = H;
`ifdef IDCNT_CANCEL_EN
        m_bal = 0;
`else
        m_ip = 0; m_dp = 0;
`endif
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic model_step();
        bit ie, de, bnd;
        int corr;
        ie = enable && inc && !m_inc_prev;
        de = enable && dec && !m_dec_prev;
        m_inc_prev = inc;
        m_dec_prev = dec;
        if (!enable) return;
        bnd  = (m_rem == 1);
        corr = 0;
`ifdef IDCNT_CANCEL_EN
        if (bnd && m_bal > 0)      begin corr = -1; m_bal--; end
        else if (bnd && m_bal < 0) begin corr = 1;  m_bal++; end
        if (ie && !de) begin if (m_bal == PMAX)  m_ovf = 1; else m_bal++; end
        if (de && !ie) begin if (m_bal == -PMAX) m_ovf = 1; else m_bal--; end
`else
        if (bnd && m_ip > 0)      begin corr = -1; m_ip--; end
        else if (bnd && m_dp > 0) begin corr = 1;  m_dp--; end
        if (ie) begin if (m_ip == PMAX) m_ovf = 1; else m_ip++; end
        if (de) begin if (m_dp == PMAX) m_ovf = 1; else m_dp++; end
`endif
        if (bnd) begin
            m_idout = !m_idout;
            m_rem   = H + corr;
        end else begin
            m_rem--;
        end
    endtask

    // One clock: model, rising edge, then settle to the falling edge.
    task automatic tick();
        model_step();
        @(posedge IDclock);
        @(negedge IDclock);
        edge_n++;
        if (idout !== prev_idout) tog_q.push_back(edge_n);
        prev_idout = idout;
    endtask

    task automatic apply_reset();
        @(negedge IDclock);
        reset = 1'b0; enable = 1'b0; inc = 1'b0; dec = 1'b0;
        repeat (2) @(negedge IDclock);
        model_reset();
        edge_n = 0;
        tog_q.delete();
        prev_idout = 1'b0;
        reset  = 1'b1;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({idout, busy, ovf} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state: idout/busy/ovf=%b%b%b expected 000", idout, busy, ovf);
        end
    endtask

    task automatic test_nominal();
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            tick();
            n_checks++;
            if ({idout, busy, ovf} !== {m_idout, m_busy(), m_ovf}) begin
                n_fail++;
                $display("FAIL nominal edge %0d: idout/busy/ovf=%b%b%b expected %b%b%b",
                         k, idout, busy, ovf, m_idout, m_busy(), m_ovf);
            end
            n_checks++;
            if (idout !== 1'(((k / 2) % 2))) begin
                n_fail++;
                $display("FAIL nominal_wave edge %0d: idout=%b expected %0d", k, idout, (k / 2) % 2);
            end
        end
    endtask

    task automatic test_inc_pulse();
        int exp_t[6];
        exp_t = '{2, 4, 6, 7, 9, 11};
        apply_reset();
        for (int k = 1; k <= 12; k++) begin
            inc = (k == 5);
            tick();
            n_checks++;
            if ({idout, busy, ovf} !== {m_idout, m_busy(), m_ovf}) begin
                n_fail++;
                $display("FAIL inc_pulse edge %0d: idout/busy/ovf=%b%b%b expected %b%b%b",
                         k, idout, busy, ovf, m_idout, m_busy(), m_ovf);
            end
            if (k == 5 || k == 6) begin
                n_checks++;
                if (busy !== (k == 5)) begin
                    n_fail++;
                    $display("FAIL inc_pulse_busy edge %0d: busy=%b expected %b", k, busy, k == 5);
                end
            end
        end
        inc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= tog_q.size() || tog_q[i] != exp_t[i]) begin
                n_fail++;
                $display("FAIL inc_pulse_toggle %0d: got %0d expected %0d", i,
                         (i < tog_q.size()) ? tog_q[i] : -1, exp_t[i]);
            end
        end
    endtask

    task automatic test_inc_held();
        int short_cnt;
        apply_reset();
        for (int k = 1; k <= 24; k++) begin
            inc = (k >= 3 && k <= 12);
            tick();
            n_checks++;
            if ({idout, busy, ovf} !== {m_idout, m_busy(), m_ovf}) begin
                n_fail++;
                $display("FAIL inc_held edge %0d: idout/busy/ovf=%b%b%b expected %b%b%b",
                         k, idout, busy, ovf, m_idout, m_busy(), m_ovf);
            end
        end
        inc = 1'b0;
        short_cnt = 0;
        for (int i = 1; i < tog_q.size(); i++)
            if (tog_q[i] - tog_q[i-1] == 1) short_cnt++;
        n_checks++;
        if (short_cnt != 1) begin
            n_fail++;
            $display("FAIL inc_held_adv_count: got %0d expected 1", short_cnt);
        end
    endtask

    task automatic test_pair();
        int exp_t[6];
`ifdef IDCNT_CANCEL_EN
        exp_t = '{2, 4, 6, 8, 10, 12};
`else
        exp_t = '{2, 4, 5, 8, 10, 12};
`endif
        // inc then dec on consecutive edges, model-checked
        apply_reset();
        for (int k = 1; k <= 16; k++) begin
            inc = (k == 3);
            dec = (k == 4);
            tick();
            n_checks++;
            if ({idout, busy, ovf} !== {m_idout, m_busy(), m_ovf}) begin
                n_fail++;
                $display("FAIL pair_seq edge %0d: idout/busy/ovf=%b%b%b expected %b%b%b",
                         k, idout, busy, ovf, m_idout, m_busy(), m_ovf);
            end
        end
        // simultaneous inc and dec edges
        apply_reset();
        for (int k = 1; k <= 14; k++) begin
            inc = (k == 3);
            dec = (k == 3);
            tick();
            n_checks++;
            if ({idout, busy, ovf} !== {m_idout, m_busy(), m_ovf}) begin
                n_fail++;
                $display("FAIL pair_simul edge %0d: idout/busy/ovf=%b%b%b expected %b%b%b",
                         k, idout, busy, ovf, m_idout, m_busy(), m_ovf);
            end
        end
        inc = 1'b0; dec = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= tog_q.size() || tog_q[i] != exp_t[i]) begin
                n_fail++;
                $display("FAIL pair_simul_toggle %0d: got %0d expected %0d", i,
                         (i < tog_q.size()) ? tog_q[i] : -1, exp_t[i]);
            end
        end
    endtask

    task automatic test_dec_saturate();
        int waited;
        apply_reset();
        for (int k = 1; k <= 200; k++) begin
            dec = (k % 2 == 1);
            tick();
            n_checks++;
            if ({idout, busy, ovf} !== {m_idout, m_busy(), m_ovf}) begin
                n_fail++;
                $display("FAIL dec_sat edge %0d: idout/busy/ovf=%b%b%b expected %b%b%b",
                         k, idout, busy, ovf, m_idout, m_busy(), m_ovf);
            end
        end
        dec = 1'b0;
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL dec_sat_ovf: ovf=%b expected 1", ovf);
        end
        waited = 0;
        while (busy === 1'b1 && waited < 120) begin
            tick();
            waited++;
            n_checks++;
            if ({idout, busy, ovf} !== {m_idout, m_busy(), m_ovf}) begin
                n_fail++;
                $display("FAIL dec_drain cycle %0d: idout/busy/ovf=%b%b%b expected %b%b%b",
                         waited, idout, busy, ovf, m_idout, m_busy(), m_ovf);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL dec_drain_end: busy/ovf=%b%b expected 01 (waited %0d)", busy, ovf, waited);
        end
    endtask

    // Runs straight after the saturation test so ovf is set going in.
    task automatic test_reset_mid();
        int exp_t[3];
        exp_t = '{2, 4, 6};
        inc = 1'b1;
        tick();
        inc = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: busy/ovf=%b%b expected 11", busy, ovf);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({idout, busy, ovf} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_async: idout/busy/ovf=%b%b%b expected 000", idout, busy, ovf);
        end
        @(negedge IDclock);
        model_reset();
        edge_n = 0;
        tog_q.delete();
        prev_idout = 1'b0;
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if ({idout, busy, ovf} !== {m_idout, m_busy(), m_ovf}) begin
                n_fail++;
                $display("FAIL reset_mid_after edge %0d: idout/busy/ovf=%b%b%b expected %b%b%b",
                         k, idout, busy, ovf, m_idout, m_busy(), m_ovf);
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= tog_q.size() || tog_q[i] != exp_t[i]) begin
                n_fail++;
                $display("FAIL reset_mid_toggle %0d: got %0d expected %0d", i,
                         (i < tog_q.size()) ? tog_q[i] : -1, exp_t[i]);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 1; k <= 1500; k++) begin
            enable = ($urandom_range(0, 9) != 0);
            if (k < 700) begin
                if ($urandom_range(0, 5) == 0) inc = ~inc;
                if ($urandom_range(0, 5) == 0) dec = ~dec;
            end else begin
                // dense phase to drive saturation on either side
                inc = (k < 1100) ? ($urandom_range(0, 1) == 1) : 1'b0;
                dec = (k >= 1100) ? ~dec : 1'b0;
            end
            tick();
            n_checks++;
            if ({idout, busy, ovf} !== {m_idout, m_busy(), m_ovf}) begin
                n_fail++;
                $display("FAIL random edge %0d: idout/busy/ovf=%b%b%b expected %b%b%b en=%b inc=%b dec=%b",
                         k, idout, busy, ovf, m_idout, m_busy(), m_ovf, enable, inc, dec);
            end
        end
        enable = 1'b1; inc = 1'b0; dec = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_inc_pulse();
        test_inc_held();
        test_pair();
        test_dec_saturate();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
